// File: rtl/ip_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_fetch_unit_pkg
// Description : Shared types and constants for the instruction fetch stage
//               and the BCD dekatron counters.
//               - IP_DEKATRON_NUM : BCD digits in the instruction pointer
//               - DEKATRON_WIDTH  : bits per BCD digit
//               - INSN_WIDTH      : instruction word width
//               - fetch_state_t   : fetch FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package ip_fetch_unit_pkg;

  localparam int IP_DEKATRON_NUM       = 6;
  localparam int DEKATRON_WIDTH        = 4;
  localparam int INSN_WIDTH            = 16;
  localparam int FETCH_TIMEOUT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

endpackage : ip_fetch_unit_pkg
`default_nettype wire

// File: rtl/ip_fetch_unit_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_updown_counter
// Description : Multi-digit BCD up/down counter with parallel load. Each digit
//               ripples a carry (count up, 9 -> 0) or borrow (count down,
//               0 -> 9) into the next. Wraps silently at all-9s / all-0s.
// Ports       : Clk, Rst_n     - clock, async active-low reset
//               load_i         - load value_o from load_val_i (beats step_i)
//               step_i, dir_i  - step by one; dir_i 0 = +1, 1 = -1
//               load_val_i     - BCD parallel load value
//               value_o        - registered BCD count
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
  import ip_fetch_unit_pkg::*;
#(
  parameter int                                 DIGITS    = IP_DEKATRON_NUM,
  parameter logic [DIGITS*DEKATRON_WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic                               load_i,
  input  logic                               step_i,
  input  logic                               dir_i,
  input  logic [DIGITS*DEKATRON_WIDTH-1:0]   load_val_i,
  output logic [DIGITS*DEKATRON_WIDTH-1:0]   value_o
);

  localparam int c_DW = DEKATRON_WIDTH;

  logic [DIGITS*c_DW-1:0] value_q;
  logic [DIGITS*c_DW-1:0] value_d;

  // lim[i] is set when digit i sits at its wrap value for the current
  // direction. Digit i moves only if every lower digit is at its limit; the
  // constant 1 at the bottom of lim_ext is the step itself entering digit 0.
  // The ripple term is an AND over independent per-digit flags, so there is
  // no combinational chain through a single vector.
  logic [DIGITS-2:0] lim;
  logic [DIGITS-1:0] lim_ext;

  assign lim_ext = {lim, 1'b1};

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [c_DW-1:0] w_cur;
    logic            w_at_lim;
    logic            w_ripple;

    assign w_cur    = value_q[gi*c_DW +: c_DW];
    assign w_at_lim = dir_i ? (w_cur == c_DW'(0)) : (w_cur == c_DW'(9));
    assign w_ripple = &lim_ext[gi:0];

    if (gi < DIGITS-1) begin : g_chain
      assign lim[gi] = w_at_lim;
    end

    assign value_d[gi*c_DW +: c_DW] =
        !w_ripple ? w_cur :
        dir_i     ? (w_at_lim ? c_DW'(9) : w_cur - c_DW'(1)) :
                    (w_at_lim ? c_DW'(0) : w_cur + c_DW'(1));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      value_q <= RESET_VAL;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (step_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule : bcd_updown_counter
`default_nettype wire

// File: rtl/ip_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ip_fetch_unit
// Description : Instruction fetch stage. Owns the BCD instruction pointer,
//               steps/loads it, issues a one-cycle Request to instruction
//               memory, waits for Ready (with timeout) and latches the word.
// Ports       : Clk, Rst_n           - clock, async active-low reset
//               Step, Dir            - advance IP +1 (Dir=0) / -1 (Dir=1), fetch
//               Fetch                - fetch at current IP
//               Load, LoadAddr       - load IP, fetch
//               Address              - current IP to memory / display
//               Request              - one-cycle read request
//               Ready, InsnIn        - memory ready and read data
//               Insn, InsnValid      - latched instruction and its valid flag
//               Busy                 - command in flight, commands ignored
//               Error                - sticky Ready timeout (cleared by Load)
// Revision    : 1.0 - initial release
// ============================================================================
module ip_fetch_unit
  import ip_fetch_unit_pkg::*;
#(
  parameter int                               IP_DIGITS      = IP_DEKATRON_NUM,
  parameter int                               DIGIT_W        = DEKATRON_WIDTH,
  parameter int                               INSN_W         = INSN_WIDTH,
  parameter logic [IP_DIGITS*DIGIT_W-1:0]     RESET_IP       = {{(IP_DIGITS-2){4'h9}}, 8'h00},
  parameter int                               TIMEOUT_CYCLES = FETCH_TIMEOUT_DEFAULT
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Step,
  input  logic                           Dir,
  input  logic                           Fetch,
  input  logic                           Load,
  input  logic [IP_DIGITS*DIGIT_W-1:0]   LoadAddr,
  output logic [IP_DIGITS*DIGIT_W-1:0]   Address,
  output logic                           Request,
  input  logic                           Ready,
  input  logic [INSN_W-1:0]              InsnIn,
  output logic [INSN_W-1:0]              Insn,
  output logic                           InsnValid,
  output logic                           Busy,
  output logic                           Error
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_t         state_q;
  logic                 request_q;
  logic                 busy_q;
  logic                 error_q;
  logic                 insn_valid_q;
  logic [INSN_W-1:0]    insn_q;
  logic [c_CNT_W-1:0]   tmo_cnt_q;

  logic w_open;
  logic w_acc_load;
  logic w_acc_step;
  logic w_acc_fetch;
  logic w_accept;

  // Full command set is open in IDLE/VALID; ERR only honours Load.
  assign w_open      = (state_q == IDLE) || (state_q == VALID);
  assign w_acc_load  = Load && (w_open || (state_q == ERR));
  assign w_acc_step  = Step && w_open && !Load;
  assign w_acc_fetch = Fetch && w_open && !Load && !Step;
  assign w_accept    = w_acc_load || w_acc_step || w_acc_fetch;

  // The pointer only moves on an accepting edge, so Address stays frozen
  // through REQ/WAIT until the instruction is latched.
  bcd_updown_counter #(
    .DIGITS    (IP_DIGITS),
    .RESET_VAL (RESET_IP)
  ) u_ip_counter (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load_i     (w_acc_load),
    .step_i     (w_acc_step),
    .dir_i      (Dir),
    .load_val_i (LoadAddr),
    .value_o    (Address)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      request_q    <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      insn_valid_q <= 1'b0;
      insn_q       <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      request_q <= 1'b0;
      case (state_q)
        IDLE, VALID, ERR: begin
          if (w_accept) begin
            state_q      <= REQ;
            request_q    <= 1'b1;
            busy_q       <= 1'b1;
            insn_valid_q <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        REQ: begin
          // Ready is deliberately not sampled here.
          state_q   <= WAIT;
          tmo_cnt_q <= '0;
        end
        WAIT: begin
          if (Ready) begin
            state_q      <= VALID;
            insn_q       <= InsnIn;
            insn_valid_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // Last permitted Ready-low cycle: the count reaches the limit
            // on this edge.
            if (tmo_cnt_q == c_TMO_LAST) begin
              state_q      <= ERR;
              error_q      <= 1'b1;
              busy_q       <= 1'b0;
              insn_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Request   = request_q;
  assign Busy      = busy_q;
  assign Error     = error_q;
  assign InsnValid = insn_valid_q;
  assign Insn      = insn_q;

endmodule : ip_fetch_unit
`default_nettype wire

// File: tb/tb_ip_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_fetch_unit
// Description : Self-checking bench for ip_fetch_unit. A small memory model
//               answers each Request with Ready two cycles later and a word
//               derived from the address. Directed command vectors plus
//               hand-written latency, busy, timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ip_fetch_unit;
  import ip_fetch_unit_pkg::*;

  localparam int AW = IP_DEKATRON_NUM * DEKATRON_WIDTH;
  localparam int IW = INSN_WIDTH;
  localparam int NV = 12;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Step = 1'b0;
  logic          Dir = 1'b0;
  logic          Fetch = 1'b0;
  logic          Load = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [AW-1:0] Address;
  logic          Request;
  logic          Ready;
  logic [IW-1:0] InsnIn;
  logic [IW-1:0] Insn;
  logic          InsnValid;
  logic          Busy;
  logic          Error;

  logic mem_stall = 1'b0;
  logic req_d1;
  int   checks = 0;
  int   errors = 0;
  int   req_count = 0;

  always #5 Clk = ~Clk;

  ip_fetch_unit dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Step      (Step),
    .Dir       (Dir),
    .Fetch     (Fetch),
    .Load      (Load),
    .LoadAddr  (LoadAddr),
    .Address   (Address),
    .Request   (Request),
    .Ready     (Ready),
    .InsnIn    (InsnIn),
    .Insn      (Insn),
    .InsnValid (InsnValid),
    .Busy      (Busy),
    .Error     (Error)
  );

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    return a[IW-1:0] ^ 16'hC35A;
  endfunction

  // Memory: Request seen in cycle n -> Ready (one cycle) in cycle n+2.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_d1 <= 1'b0;
      Ready  <= 1'b0;
      InsnIn <= 16'hDEAD;
    end else begin
      req_d1 <= Request & ~mem_stall;
      Ready  <= req_d1;
      InsnIn <= req_d1 ? rom(Address) : 16'hDEAD;
    end
  end

  always @(posedge Clk) if (Rst_n && Request) req_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse one command for a single edge, then wait (bounded) for the result.
  task automatic run_cmd(input logic ld, input logic st, input logic fe,
                         input logic dr, input logic [AW-1:0] la, output bit done);
    @(negedge Clk);
    Load = ld; Step = st; Fetch = fe; Dir = dr; LoadAddr = la;
    @(negedge Clk);
    Load = 1'b0; Step = 1'b0; Fetch = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (InsnValid || Error) begin
        done = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  typedef struct {
    logic          ld;
    logic          st;
    logic          fe;
    logic          dr;
    logic [AW-1:0] la;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int r0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000009, 24'h000009};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000010};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'h999999};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000300, 24'h000300};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000299};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h123459, 24'h123459};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h123460};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h100000, 24'h100000};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'h099999};

    // ---- reset state ----
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("reset Address", 32'(Address), 32'h999900);
    chk("reset InsnValid", 32'(InsnValid), 0);
    chk("reset Request", 32'(Request), 0);
    chk("reset Busy", 32'(Busy), 0);
    chk("reset Error", 32'(Error), 0);
    chk("reset Insn", 32'(Insn), 0);

    // ---- fetch latency: accept t, Request t+1, Ready t+3, valid t+4 ----
    r0 = req_count;
    Fetch = 1'b1;
    @(negedge Clk);
    Fetch = 1'b0;
    chk("lat t+1 Request", 32'(Request), 1);
    chk("lat t+1 Busy", 32'(Busy), 1);
    @(negedge Clk);
    chk("lat t+2 Request", 32'(Request), 0);
    chk("lat t+2 InsnValid", 32'(InsnValid), 0);
    @(negedge Clk);
    chk("lat t+3 Ready", 32'(Ready), 1);
    chk("lat t+3 InsnValid", 32'(InsnValid), 0);
    @(negedge Clk);
    chk("lat t+4 InsnValid", 32'(InsnValid), 1);
    chk("lat t+4 Insn", 32'(Insn), 32'(rom(24'h999900)));
    chk("lat t+4 Busy", 32'(Busy), 0);
    chk("lat requests", 32'(req_count - r0), 1);

    // ---- directed command vectors ----
    for (int i = 0; i < NV; i++) begin
      r0 = req_count;
      run_cmd(vecs[i].ld, vecs[i].st, vecs[i].fe, vecs[i].dr, vecs[i].la, done);
      chk($sformatf("vec%0d done", i), 32'(done), 1);
      chk($sformatf("vec%0d Address", i), 32'(Address), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d Insn", i), 32'(Insn), 32'(rom(vecs[i].exp_addr)));
      chk($sformatf("vec%0d requests", i), 32'(req_count - r0), 1);
      chk($sformatf("vec%0d Error", i), 32'(Error), 0);
    end

    // ---- commands during Busy are ignored ----
    @(negedge Clk);
    r0 = req_count;
    Load = 1'b1; LoadAddr = 24'h000500;
    @(negedge Clk);
    LoadAddr = 24'h000700; Step = 1'b1; Fetch = 1'b1; Dir = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("busy t+3 Busy", 32'(Busy), 1);
    chk("busy t+3 Address", 32'(Address), 32'h000500);
    @(negedge Clk);
    Load = 1'b0; Step = 1'b0; Fetch = 1'b0;
    chk("busy InsnValid", 32'(InsnValid), 1);
    chk("busy Address", 32'(Address), 32'h000500);
    chk("busy Insn", 32'(Insn), 32'(rom(24'h000500)));
    repeat (4) @(negedge Clk);
    chk("busy requests", 32'(req_count - r0), 1);
    chk("busy still valid", 32'(InsnValid), 1);

    // ---- Ready timeout ----
    mem_stall = 1'b1;
    @(negedge Clk);
    Fetch = 1'b1;
    @(negedge Clk);
    Fetch = 1'b0;
    repeat (16) @(negedge Clk);
    chk("tmo t+17 Error", 32'(Error), 0);
    chk("tmo t+17 Busy", 32'(Busy), 1);
    @(negedge Clk);
    chk("tmo t+18 Error", 32'(Error), 1);
    chk("tmo t+18 InsnValid", 32'(InsnValid), 0);
    chk("tmo t+18 Busy", 32'(Busy), 0);
    r0 = req_count;
    Step = 1'b1; Fetch = 1'b1; Dir = 1'b0;
    @(negedge Clk);
    Step = 1'b0; Fetch = 1'b0;
    @(negedge Clk);
    chk("err step requests", 32'(req_count - r0), 0);
    chk("err step Address", 32'(Address), 32'h000500);
    chk("err step Error", 32'(Error), 1);
    mem_stall = 1'b0;
    run_cmd(1'b1, 1'b0, 1'b0, 1'b0, 24'h000100, done);
    chk("err load done", 32'(done), 1);
    chk("err load Error", 32'(Error), 0);
    chk("err load InsnValid", 32'(InsnValid), 1);
    chk("err load Address", 32'(Address), 32'h000100);
    chk("err load Insn", 32'(Insn), 32'(rom(24'h000100)));

    // ---- asynchronous reset in WAIT ----
    @(negedge Clk);
    Fetch = 1'b1;
    @(negedge Clk);
    Fetch = 1'b0;
    @(negedge Clk);
    chk("rst pre Busy", 32'(Busy), 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("rst Request", 32'(Request), 0);
    chk("rst InsnValid", 32'(InsnValid), 0);
    chk("rst Address", 32'(Address), 32'h999900);
    chk("rst Busy", 32'(Busy), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    run_cmd(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000, done);
    chk("post rst done", 32'(done), 1);
    chk("post rst Address", 32'(Address), 32'h999900);
    chk("post rst Insn", 32'(Insn), 32'(rom(24'h999900)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ip_fetch_unit
`default_nettype wire

// File: doc/ip_fetch_unit.md
Name: ip_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the IP instruction memory. It owns the BCD instruction pointer (one 4-bit BCD digit per dekatron). It steps the pointer forward or backward, or loads it, then runs the Request/Ready handshake with the memory. The fetched instruction is latched and presented to the decode/sequencer stage with a valid flag.

Parameters:
IP_DIGITS, IP_DEKATRON_NUM (package), number of BCD digits in IP
DIGIT_W, DEKATRON_WIDTH (package, =4), bits per digit
INSN_W, INSN_WIDTH (package), instruction width
RESET_IP, upper (IP_DIGITS-2) digits all 9, low 2 digits 0 (bootloader ROM base), IP value after reset
TIMEOUT_CYCLES, 16, max cycles waiting for Ready before error

Ports:
Clk  in  1  clock
Rst_n  in  1  reset
Step  in  1  advance IP by one in direction Dir, then fetch
Dir  in  1  0 = forward (+1), 1 = backward (-1)
Fetch  in  1  fetch at current IP, no advance
Load  in  1  load IP from LoadAddr, then fetch
LoadAddr  in  IP_DIGITS*DIGIT_W  BCD load value
Address  out  IP_DIGITS*DIGIT_W  IP to memory, also current IP to debug/display
Request  out  1  one-cycle memory read request
Ready  in  1  memory ready, data valid
InsnIn  in  INSN_W  memory read data
Insn  out  INSN_W  latched instruction
InsnValid  out  1  Insn holds the instruction at Address
Busy  out  1  command in flight; commands ignored
Error  out  1  sticky Ready-timeout flag

Behaviour:
- Reset (Rst_n is asynchronous, active-low; clock is Clk). Reset values: Address=RESET_IP, Request=0, Insn=0, InsnValid=0, Busy=0, Error=0, state IDLE, timeout counter 0.
- States:
  - IDLE: no valid instruction.
  - REQ: Request=1 for exactly one cycle.
  - WAIT: Request=0, counting.
  - VALID: InsnValid=1.
  - ERR: Error=1.
- Command acceptance happens only in IDLE, VALID or ERR. Busy=1 in REQ/WAIT, and commands there are ignored.
- Priority: Load > Step > Fetch. In ERR only Load is accepted. Load clears Error.
- On the accepting edge:
  - IP is updated (Load: IP<=LoadAddr; Step: IP<=IP±1; Fetch: unchanged).
  - InsnValid<=0.
  - State goes to REQ.
- REQ to WAIT unconditionally. Address is stable from REQ until the instruction is latched.
- Ready is ignored in REQ. WAIT exits on the first cycle with Ready=1: Insn<=InsnIn, state goes to VALID.
- Latency with a memory that has no extra delay:
  - accept edge t
  - Request high in cycle t+1
  - Ready high in cycle t+3
  - InsnValid=1 from cycle t+4
- Timeout: the counter clears on entering WAIT and increments each WAIT cycle with Ready=0. When it reaches TIMEOUT_CYCLES, state goes to ERR, Error=1 and InsnValid=0.
- BCD arithmetic is a per-digit ripple carry/borrow. Increment: digit 9 becomes 0 with carry. Decrement: digit 0 becomes 9 with borrow.
- Wrap-around: all-9s +1 gives all-0s; all-0s -1 gives all-9s. No flag is raised on wrap.
- LoadAddr digits >9 are out of contract. The bench must not drive them; RTL does not check them.
- Reset mid-fetch returns to IDLE with the reset values above. The memory side tolerates the dropped request.

Decomposition:
- Shared package:
  - existing IP_DEKATRON_NUM, DEKATRON_WIDTH, INSN_WIDTH
  - new enum fetch_state_t {IDLE, REQ, WAIT, VALID, ERR}
  - localparam FETCH_TIMEOUT_DEFAULT
- One sub-module, bcd_updown_counter (parameter DIGITS). It has load, step and dir inputs, a parallel load value, and a registered BCD output. It contains the digit carry/borrow chain and is reusable for the AP/data-pointer counters.

Test Plan:
- Release reset, IP_DIGITS=6: Address=24'h999900, InsnValid=0. Pulse Fetch at t. Expect Request=1 only in t+1, InsnValid=1 at t+4, Insn = ROM word 0.
- Load LoadAddr=24'h000009, then Step Dir=0. Expect Address=24'h000010 and one Request per command.
- Load 24'h000000, then Step Dir=1. Expect Address=24'h999999. Then Step Dir=0. Expect Address=24'h000000 (both wraps).
- Step, Fetch and Load pulsed during Busy. Expect them ignored: Address unchanged, no second Request. Load+Step on the same edge: Load wins.
- Memory model holding Ready=0 for 16 WAIT cycles. Expect Error=1 and ERR. Step then ignored. Load 24'h000100 clears Error and fetches.
- Assert Rst_n low in WAIT. Expect immediate Request=0, InsnValid=0 and Address=24'h999900, asynchronously before the next Clk edge.
